// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot-time loader for the instruction memory.
// When the board load switch is pressed, this block holds the core in reset.
// It packs little-endian UART bytes into 32-bit words and writes DEPTH words
// starting at address 0. Once the image is complete, the core is released.
// Optional build macro: LOAD_CHECKSUM_EN. When defined, the block expects one
// trailing byte equal to the XOR of every image byte. If that byte does not
// match, the block enters ERROR and keeps the core held.
module imem_load_ctrl #(
  parameter int DEPTH           = 32,
  parameter int ADDR_W          = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              switch,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} state_e;

  // switch conditioning
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [1:0]       fill_q, fill_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             armed_q, armed_d;
  logic             press;

  // load engine
  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_busy_q, load_busy_d;
  logic              load_done_q, load_done_d;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              load_err_q, load_err_d;
`endif

  // Synchronise and debounce the switch. A press is accepted only after the
  // debounced level has been seen low, so a switch held through reset is ignored.
  always_comb begin
    sync1_d   = switch;
    sync2_d   = sync1_q;
    fill_d    = {fill_q[0], 1'b1};
    deb_d     = deb_q;
    deb_cnt_d = '0;
    armed_d   = armed_q | (fill_q[1] & ~sync2_q & ~deb_q);
    press     = 1'b0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
        press = sync2_q & armed_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Load FSM: assemble bytes into words, pulse writes, decode registered status
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    shift_d      = shift_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef LOAD_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE, RUN
`ifdef LOAD_CHECKSUM_EN
      , ERROR
`endif
      : begin
        if (press) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          shift_d    = '0;
`ifdef LOAD_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      LOAD: begin
        if (rx_valid) begin
          shift_d    = {rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOAD_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_wdata_d = {rx_data, shift_q};
            imem_addr_d  = word_cnt_q;
            word_cnt_d   = word_cnt_q + 1'b1;
            if (word_cnt_q == WORD_LAST) begin
`ifdef LOAD_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = RUN;
`endif
            end
          end
        end
      end
`ifdef LOAD_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          state_d = (rx_data == csum_q) ? RUN : ERROR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    cpu_hold_d  = (state_d != RUN);
    load_busy_d = (state_d == LOAD) || (state_d == CHECK);
    load_done_d = (state_d == RUN);
`ifdef LOAD_CHECKSUM_EN
    load_err_d  = (state_d == ERROR);
`endif
  end

  // State and output registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      fill_q       <= '0;
      deb_q        <= 1'b0;
      deb_cnt_q    <= '0;
      armed_q      <= 1'b0;
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      shift_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      csum_q       <= '0;
      load_err_q   <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      fill_q       <= fill_d;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shift_q      <= shift_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_busy_q  <= load_busy_d;
      load_done_q  <= load_done_d;
`ifdef LOAD_CHECKSUM_EN
      csum_q       <= csum_d;
      load_err_q   <= load_err_d;
`endif
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_busy  = load_busy_q;
  assign load_done  = load_done_q;
`ifdef LOAD_CHECKSUM_EN
  assign load_err   = load_err_q;
`else
  assign load_err   = 1'b0;
`endif

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Boot-time programming controller for the instruction memory of the single-cycle RISC-V core.
- On a debounced press of the board load switch, it:
  - holds the CPU in reset;
  - assembles a little-endian byte stream from the UART receiver into 32-bit words;
  - writes the words to instruction memory at consecutive addresses starting at 0;
  - releases the CPU when the full image is written.
- Sits between the UART RX block, the instruction memory write port and the core reset.

Parameters:
- DEPTH, 32, number of 32-bit words per image; power of two, at least 2.
- ADDR_W, 5, instruction memory word-address width; must equal log2(DEPTH).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the switch level is accepted.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- switch  input  1  raw, asynchronous load switch.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- rx_data  input  8  received byte.
- imem_we  output  1  instruction memory write enable, one-cycle pulse.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_hold  output  1  active-high reset/hold to the core.
- load_busy  output  1  high while an image is being received.
- load_done  output  1  high once a complete image has been loaded and accepted.
- load_err  output  1  checksum failure flag (see Optional Feature).

Behaviour:
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, load_busy=0, load_done=0, load_err=0.
  - State IDLE; all counters and the shift register cleared; debounced level=0.
- Switch conditioning:
  - 2-flop synchroniser on switch.
  - Counter increments while the synchronised value differs from the debounced level; it clears whenever they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - A 0->1 transition of the debounced level produces a one-cycle internal press pulse.
- FSM states: IDLE, LOAD, CHECK, RUN, ERROR.
  - IDLE: cpu_hold=1. Press -> LOAD.
  - LOAD: load_busy=1, cpu_hold=1, load_done=0, load_err=0.
    - Entry clears the byte count (0..3), word count (0..DEPTH-1) and checksum.
    - Each rx_valid shifts rx_data into the word. Byte 0 goes to bits [7:0] and byte 3 to bits [31:24].
    - On the edge that accepts byte 3: imem_we=1, imem_wdata=the assembled word, imem_addr=the word count. These are registered and valid for exactly the following cycle; then imem_we=0. The word count increments and the byte count wraps to 0.
    - On the edge that accepts byte 3 of word DEPTH-1: go to CHECK when LOAD_CHECKSUM_EN is defined, otherwise go to RUN.
  - RUN: cpu_hold=0, load_done=1, load_busy=0.
    - Press -> LOAD. cpu_hold=1 and load_done=0 from that edge.
  - CHECK and ERROR: see Optional Feature.
- Ignored inputs:
  - rx_valid in IDLE, RUN and ERROR.
  - Press in LOAD and CHECK.
- rx_valid on back-to-back cycles is fully supported; no byte is dropped, including during an imem_we pulse.
- imem_addr holds its last value when imem_we=0.
- Reset mid-load:
  - All outputs return to reset values immediately (asynchronous).
  - A partially written image is not retried; a fresh press is required.
- A switch held high across reset does not produce a press. The debounced level must first see 0 then 1.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- Defined:
  - A running XOR of all 4*DEPTH image bytes is kept.
  - In CHECK (load_busy=1, cpu_hold=1), the next rx_valid byte is compared with the XOR.
  - Equal -> RUN.
  - Unequal -> ERROR: load_err=1, cpu_hold=1, load_done=0, load_busy=0. A press -> LOAD, which clears load_err.
- Undefined:
  - No CHECK or ERROR state; the last word goes directly to RUN.
  - load_err is tied to 0.

Test Plan:
- Reset, then hold switch=0 for 100 cycles -> cpu_hold=1, load_done=0, no imem_we pulse.
- Switch glitch high for DEBOUNCE_CYCLES-4 cycles -> no state change. Switch held high for DEBOUNCE_CYCLES+4 cycles -> load_busy=1 within DEBOUNCE_CYCLES+4 cycles.
- Full load:
  - Stimulus: press, then 128 bytes where byte k=k[7:0], with rx_valid every cycle.
  - Expected: 32 imem_we pulses; addr n carries word {4n+3,4n+2,4n+1,4n}, e.g. addr 0=0x03020100 and addr 31=0x7F7E7D7C.
  - After the last pulse: cpu_hold=0, load_done=1.
- Press during LOAD after 10 bytes -> ignored; the load completes normally with the same addresses and data.
- Reset asserted after word 5 -> outputs return to reset values immediately. A following press plus 128 bytes -> writes restart at addr 0.
- LOAD_CHECKSUM_EN:
  - Image above plus trailing byte 0x00 (the XOR of 0..127) -> RUN, load_err=0.
  - Same image plus trailing byte 0xFF -> load_err=1, cpu_hold=1. A new press clears load_err.
